// File: rtl/sb_ctrl_pkg.sv
// Shared types and default sizing for the scoreboard commit sequencer.
package sb_ctrl_pkg;

  localparam int unsigned SbEntries   = 8;
  localparam int unsigned CommitPorts = 2;
  localparam int unsigned WbPorts     = 4;
  localparam int unsigned SbIdxW      = $clog2(SbEntries);

  typedef logic [SbIdxW-1:0] sb_idx_t;
  typedef logic [SbIdxW:0]   sb_cnt_t;

endpackage

// File: rtl/sb_ptr_ring.sv
// Modulo-2^Width ring pointer that advances by a variable amount each cycle.
module sb_ptr_ring #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [Width-1:0] inc,
  output logic [Width-1:0] ptr
);

  logic [Width-1:0] ptr_d, ptr_q;

  // Power-of-two depth, so natural overflow gives the modulo wrap.
  always_comb begin
    ptr_d = ptr_q + inc;
    if (clr) ptr_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sb_commit_ctrl.sv
// In-order scoreboard allocator: hands out entries, tracks writeback completion and
// offers the oldest completed entries to commit in program order.
module sb_commit_ctrl
  import sb_ctrl_pkg::*;
#(
  parameter int unsigned NR_SB_ENTRIES   = SbEntries,
  parameter int unsigned NR_COMMIT_PORTS = CommitPorts,
  parameter int unsigned NR_WB_PORTS     = WbPorts,
  parameter int unsigned IDX_W           = $clog2(NR_SB_ENTRIES)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             issue_valid_i,
  output logic                             issue_ready_o,
  output logic [IDX_W-1:0]                 issue_idx_o,
  input  logic [NR_WB_PORTS-1:0]           wb_valid_i,
  input  logic [NR_WB_PORTS*IDX_W-1:0]     wb_idx_i,
  output logic [NR_COMMIT_PORTS-1:0]       commit_valid_o,
  output logic [NR_COMMIT_PORTS*IDX_W-1:0] commit_idx_o,
  input  logic [NR_COMMIT_PORTS-1:0]       commit_ack_i,
  output logic                             full_o,
  output logic                             empty_o,
  output logic [IDX_W:0]                   count_o
);

  logic [NR_SB_ENTRIES-1:0] valid_d, valid_q;
  logic [NR_SB_ENTRIES-1:0] done_d, done_q;
  logic [IDX_W:0]           count_d, count_q;

  logic [IDX_W-1:0]           issue_ptr, commit_ptr;
  logic [IDX_W-1:0]           c_idx [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0] offer, honoured;
  logic [IDX_W:0]             n_commit;
  logic                       issue_fire;

  assign full_o        = (count_q == (IDX_W+1)'(NR_SB_ENTRIES));
  assign empty_o       = (count_q == '0);
  assign count_o       = count_q;
  assign issue_ready_o = !full_o && !flush_i;
  assign issue_idx_o   = issue_ptr;
  assign issue_fire    = issue_valid_i && issue_ready_o;

  // Each port is valid only behind a valid older port, and acks must be contiguous from port 0.
  always_comb begin
    offer    = '0;
    honoured = '0;
    n_commit = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      c_idx[k] = commit_ptr + IDX_W'(k);
      if (k == 0) begin
        offer[k]    = valid_q[c_idx[k]] && done_q[c_idx[k]] && !flush_i;
        honoured[k] = offer[k] && commit_ack_i[k];
      end else begin
        offer[k]    = offer[k-1] && valid_q[c_idx[k]] && done_q[c_idx[k]];
        honoured[k] = honoured[k-1] && offer[k] && commit_ack_i[k];
      end
      n_commit = n_commit + (IDX_W+1)'(honoured[k]);
    end
  end

  assign commit_valid_o = offer;

  for (genvar g = 0; g < NR_COMMIT_PORTS; g++) begin : g_commit_idx
    assign commit_idx_o[g*IDX_W +: IDX_W] = c_idx[g];
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    count_d = count_q;
    if (flush_i) begin
      valid_d = '0;
      done_d  = '0;
      count_d = '0;
    end else begin
      for (int k = 0; k < NR_WB_PORTS; k++) begin
        if (wb_valid_i[k] && valid_q[wb_idx_i[k*IDX_W +: IDX_W]]) begin
          done_d[wb_idx_i[k*IDX_W +: IDX_W]] = 1'b1;
        end
      end
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
        if (honoured[k]) begin
          valid_d[c_idx[k]] = 1'b0;
          done_d[c_idx[k]]  = 1'b0;
        end
      end
      // The issue slot is never valid, so it cannot collide with writeback or commit.
      if (issue_fire) begin
        valid_d[issue_ptr] = 1'b1;
        done_d[issue_ptr]  = 1'b0;
      end
      count_d = count_q + (IDX_W+1)'(issue_fire) - n_commit;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      done_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  sb_ptr_ring #(
    .Width (IDX_W)
  ) u_issue_ptr (
    .clk (clk_i),
    .rst (rst_i),
    .clr (flush_i),
    .inc (IDX_W'(issue_fire)),
    .ptr (issue_ptr)
  );

  sb_ptr_ring #(
    .Width (IDX_W)
  ) u_commit_ptr (
    .clk (clk_i),
    .rst (rst_i),
    .clr (flush_i),
    .inc (IDX_W'(n_commit)),
    .ptr (commit_ptr)
  );

endmodule

// File: tb/tb_sb_commit_ctrl.sv
// Randomized and directed bench for sb_commit_ctrl against a queue-based in-order model.
module tb_sb_commit_ctrl;
  import sb_ctrl_pkg::*;

  localparam int unsigned N  = SbEntries;
  localparam int unsigned P  = CommitPorts;
  localparam int unsigned W  = WbPorts;
  localparam int unsigned IW = SbIdxW;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            issue_valid;
  logic            issue_ready;
  sb_idx_t         issue_idx;
  logic [W-1:0]    wb_valid;
  logic [W*IW-1:0] wb_idx;
  logic [P-1:0]    commit_valid;
  logic [P*IW-1:0] commit_idx;
  logic [P-1:0]    commit_ack;
  logic            full;
  logic            empty;
  sb_cnt_t         count;

  sb_commit_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .issue_valid_i  (issue_valid),
    .issue_ready_o  (issue_ready),
    .issue_idx_o    (issue_idx),
    .wb_valid_i     (wb_valid),
    .wb_idx_i       (wb_idx),
    .commit_valid_o (commit_valid),
    .commit_idx_o   (commit_idx),
    .commit_ack_i   (commit_ack),
    .full_o         (full),
    .empty_o        (empty),
    .count_o        (count)
  );

  always #5 clk = ~clk;

  // Model: in-flight entries held oldest-first in a queue, plus per-index completion flags.
  int q[$];
  bit mdone[N];
  int m_issue;
  int m_commit;
  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N; i++) mdone[i] = 1'b0;
    m_issue  = 0;
    m_commit = 0;
  endtask

  task automatic check_all();
    bit cv0, cv1;
    cv0 = (q.size() >= 1) && mdone[q[0]] && !flush;
    cv1 = cv0 && (q.size() >= 2) && mdone[q[1]];
    chk("issue_ready", issue_ready, (q.size() < N) && !flush);
    chk("issue_idx", issue_idx, m_issue);
    chk("commit_valid", commit_valid, {30'd0, cv1, cv0});
    chk("commit_idx", commit_idx, ((m_commit + 1) % N) * N + m_commit);
    chk("count", count, q.size());
    chk("full", full, q.size() == N);
    chk("empty", empty, q.size() == 0);
  endtask

  task automatic drive(input bit iv, input logic [W-1:0] wv, input logic [W*IW-1:0] wi,
                       input logic [P-1:0] ack, input bit fl);
    @(negedge clk);
    issue_valid = iv;
    wb_valid    = wv;
    wb_idx      = wi;
    commit_ack  = ack;
    flush       = fl;
    #1;
    check_all();
  endtask

  // Advance one clock and apply the same inputs to the model.
  task automatic tick();
    int  n;
    bit  rdy;
    int  idx;
    @(posedge clk);
    if (flush) begin
      model_reset();
    end else begin
      rdy = q.size() < N;
      n = 0;
      if (commit_ack[0] && q.size() >= 1 && mdone[q[0]]) begin
        n = 1;
        if (commit_ack[1] && q.size() >= 2 && mdone[q[1]]) n = 2;
      end
      for (int k = 0; k < W; k++) begin
        if (wb_valid[k]) begin
          idx = int'(wb_idx[k*IW +: IW]);
          foreach (q[j]) if (q[j] == idx) mdone[idx] = 1'b1;
        end
      end
      repeat (n) void'(q.pop_front());
      m_commit = (m_commit + n) % N;
      if (issue_valid && rdy) begin
        q.push_back(m_issue);
        mdone[m_issue] = 1'b0;
        m_issue = (m_issue + 1) % N;
      end
    end
  endtask

  task automatic cycle(input bit iv, input logic [W-1:0] wv, input logic [W*IW-1:0] wi,
                       input logic [P-1:0] ack, input bit fl);
    drive(iv, wv, wi, ack, fl);
    tick();
  endtask

  task automatic wb1(input int idx);
    cycle(1'b0, 4'b0001, (W*IW)'(idx), 2'b00, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    issue_valid = 1'b0;
    wb_valid    = '0;
    commit_ack  = '0;
    flush       = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    flush = 1'b0;
    issue_valid = 1'b0;
    wb_valid = '0;
    wb_idx = '0;
    commit_ack = '0;
    model_reset();
    #1;
    check_all();
    chk("reset_commit_idx", commit_idx, 6'b001_000);
    #12 rst = 1'b0;

    // Fill with no writeback, then a rejected ninth request.
    for (int i = 0; i < 8; i++) cycle(1'b1, '0, '0, 2'b00, 1'b0);
    drive(1'b1, '0, '0, 2'b00, 1'b0);
    chk("fill_full", full, 1);
    chk("fill_ready", issue_ready, 0);
    chk("fill_count", count, 8);
    tick();
    cycle(1'b0, '0, '0, 2'b00, 1'b1);

    // Out-of-order completion.
    for (int i = 0; i < 3; i++) cycle(1'b1, '0, '0, 2'b00, 1'b0);
    wb1(2);
    wb1(1);
    drive(1'b0, 4'b0001, '0, 2'b00, 1'b0);
    chk("ooo_before_wb0", commit_valid, 2'b00);
    tick();
    drive(1'b0, '0, '0, 2'b11, 1'b0);
    chk("ooo_cv", commit_valid, 2'b11);
    chk("ooo_idx", commit_idx, 6'b001_000);
    tick();
    drive(1'b0, '0, '0, 2'b00, 1'b0);
    chk("ooo_count", count, 1);
    chk("ooo_idx0", commit_idx[IW-1:0], 2);
    tick();

    // Ack on port 1 alone is dropped.
    wb1(2);
    cycle(1'b0, '0, '0, 2'b01, 1'b0);
    cycle(1'b1, '0, '0, 2'b00, 1'b0);
    cycle(1'b1, '0, '0, 2'b00, 1'b0);
    cycle(1'b0, 4'b0011, {6'd0, 3'd4, 3'd3}, 2'b00, 1'b0);
    cycle(1'b0, '0, '0, 2'b10, 1'b0);
    drive(1'b0, '0, '0, 2'b11, 1'b0);
    chk("ack1_count", count, 2);
    chk("ack1_idx0", commit_idx[IW-1:0], 3);
    tick();

    // Steady-state wrap: issue, complete and commit each cycle.
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 4'b0001, (W*IW)'((m_issue + N - 1) % N), 2'b01, 1'b0);
      chk("wrap_bound", count <= 8, 1);
    end
    cycle(1'b0, '0, '0, 2'b00, 1'b1);

    // Full with commit and issue in the same cycle.
    for (int i = 0; i < 8; i++) cycle(1'b1, '0, '0, 2'b00, 1'b0);
    wb1(0);
    drive(1'b1, '0, '0, 2'b01, 1'b0);
    chk("full_ready", issue_ready, 0);
    tick();
    drive(1'b0, '0, '0, 2'b00, 1'b0);
    chk("full_after_ready", issue_ready, 1);
    chk("full_after_idx", issue_idx, 0);
    tick();
    cycle(1'b0, '0, '0, 2'b00, 1'b1);

    // Flush discards coincident writeback and acks.
    for (int i = 0; i < 5; i++) cycle(1'b1, '0, '0, 2'b00, 1'b0);
    wb1(0);
    cycle(1'b1, 4'b0011, {6'd0, 3'd1, 3'd3}, 2'b11, 1'b1);
    drive(1'b0, 4'b0001, (W*IW)'(3), 2'b00, 1'b0);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_idx", issue_idx, 0);
    tick();
    drive(1'b0, '0, '0, 2'b00, 1'b0);
    chk("flush_late_wb", commit_valid, 2'b00);
    tick();

    // Async reset in the middle of a burst.
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0001, (W*IW)'(i), 2'b01, 1'b0);
    async_reset();
    chk("arst_count", count, 0);
    wb1(1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [W*IW-1:0] wi;
      logic [W-1:0]    wv;
      wv = '0;
      for (int k = 0; k < W; k++) begin
        wv[k] = ($urandom_range(0, 2) == 0);
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          wi[k*IW +: IW] = IW'(q[$urandom_range(0, q.size() - 1)]);
        else
          wi[k*IW +: IW] = IW'($urandom_range(0, N - 1));
      end
      if ($urandom_range(0, 99) == 0) async_reset();
      else cycle(1'($urandom_range(0, 1)), wv, wi, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sb_commit_ctrl.md
Name: sb_commit_ctrl

Overview:
- In-order scoreboard allocation and commit sequencer for the 64-bit core.
- Hands out scoreboard entry indices to the issue stage in a circular order.
- Tracks writeback completion per entry.
- Presents up to NR_COMMIT_PORTS oldest completed entries per cycle to the commit stage, strictly in program order.
- Sits between issue, the writeback ports and commit. It sequences only the scoreboard resource; it stores no instruction payload.

Parameters:
- NR_SB_ENTRIES, 8: scoreboard depth. Must be a power of 2 and ≥ NR_COMMIT_PORTS.
- NR_COMMIT_PORTS, 2: commit ports per cycle. Legal values are 1 or 2.
- NR_WB_PORTS, 4: writeback ports, one per functional-unit group.
- IDX_W, $clog2(NR_SB_ENTRIES): width of an entry index.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- flush_i  in  1  kill all in-flight entries
- issue_valid_i  in  1  issue requests an entry
- issue_ready_o  out  1  entry available
- issue_idx_o  out  IDX_W  index allocated on the handshake
- wb_valid_i  in  NR_WB_PORTS  writeback strobe per port
- wb_idx_i  in  NR_WB_PORTS*IDX_W  entry completed, per port
- commit_valid_o  out  NR_COMMIT_PORTS  commit port k holds a done entry
- commit_idx_o  out  NR_COMMIT_PORTS*IDX_W  entry index per commit port
- commit_ack_i  in  NR_COMMIT_PORTS  commit consumed port k
- full_o  out  1  count == NR_SB_ENTRIES
- empty_o  out  1  count == 0
- count_o  out  IDX_W+1  occupied entries

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous, active-high. On reset:
  - valid and done vectors = 0
  - issue_ptr = 0, commit_ptr = 0, count = 0
  - so issue_ready_o=1, issue_idx_o=0, commit_valid_o=0, commit_idx_o={1,0}, full_o=0, empty_o=1, count_o=0.
- Issue:
  - issue_ready_o = !full_o && !flush_i.
  - issue_idx_o = issue_ptr, presented combinationally.
  - On issue_valid_i && issue_ready_o: set valid[issue_ptr]=1, done[issue_ptr]=0, issue_ptr++ (modulo NR_SB_ENTRIES; wraps 7→0).
- Writeback:
  - For each k with wb_valid_i[k]: done[wb_idx_i[k]] is set at the next edge, only if that entry is valid.
  - A writeback to an invalid entry is ignored (no error).
  - Duplicate indices across ports are harmless.
  - Writeback→commit_valid_o latency is 1 cycle.
- Commit offer (combinational from registered state):
  - c0 = commit_ptr. commit_valid_o[0] = valid[c0] && done[c0] && !flush_i.
  - c1 = c0+1 (modulo). commit_valid_o[1] = commit_valid_o[0] && valid[c1] && done[c1].
  - Port 1 is never valid while port 0 is invalid (in-order rule).
  - commit_idx_o always shows c0 and c1, even when not valid.
- Commit accept:
  - ack[0] is honoured only if commit_valid_o[0].
  - ack[1] is honoured only if ack[0] is honoured and commit_valid_o[1]. An ack[1] without ack[0] is dropped.
  - For each honoured port: clear valid and done, and advance commit_ptr by the number honoured (0, 1 or 2).
- Count: count_next = count + issued − committed. Issue and commit in the same cycle are legal, including when full (commit frees a slot only for the next cycle, since ready is based on the registered count).
- Flush (synchronous, highest priority): at the next edge valid=0, done=0, both pointers=0, count=0.
  - Issue, writeback and acks presented in the flush cycle are discarded.
  - issue_ready_o and commit_valid_o are forced 0 during flush_i.
- Reset mid-operation: all state returns to the reset values immediately (async). Outstanding writebacks arriving afterwards hit invalid entries and are ignored.
- NR_COMMIT_PORTS=1: port 1 logic is absent.

Decomposition:
- Package sb_ctrl_pkg:
  - typedef sb_idx_t (logic [IDX_W-1:0])
  - typedef sb_cnt_t (logic [IDX_W:0])
  - localparam defaults taken from the core configuration: scoreboard entries 8, commit ports 2.
- One sub-module, sb_ptr_ring: modulo pointer with increment-by-N input. Instantiated twice (issue_ptr, commit_ptr).

Test Plan:
- Fill: 8 issues with no writeback → issue_idx_o 0..7, full_o=1 and issue_ready_o=0 after the 8th; a 9th request is not accepted; count_o=8.
- Out-of-order completion: issue 0,1,2; writeback 2 then 1 then 0 on separate cycles → commit_valid_o=00 until 0 is done; one cycle after wb(0), commit_valid_o=11 with idx {1,0}; ack=11 → count_o=1, commit_idx_o[0]=2.
- Ack-1-only: entries 3,4 done, ack=10 (port 1 only) → nothing commits, commit_ptr unchanged, count unchanged.
- Wrap: issue and commit 14 entries in steady state → issue_idx_o wraps 7→0, commit_idx_o {0,7} at the boundary, count never exceeds 8.
- Full with simultaneous commit and issue: at count=8, ack entry 0 while issue_valid_i=1 → no issue that cycle; next cycle issue_ready_o=1, issue_idx_o=0.
- Flush: 5 in flight, flush_i with wb_valid_i and ack asserted → next cycle count_o=0, empty_o=1, issue_idx_o=0; a late writeback to idx 3 leaves commit_valid_o=0. Async rst_i pulse mid-burst → same state with no clock edge.
